// File: rtl/mesm6_alu_ctl_pkg.sv
// rtl/mesm6_alu_ctl_pkg.sv - ALU opcodes, sequencer state encoding and timeout default
package mesm6_alu_ctl_pkg;

  localparam int ALU_OP_WIDTH = 3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP              = 3'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND              = 3'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR               = 3'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR              = 3'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD_CARRY_AROUND = 3'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_FMUL             = 3'd5;

  localparam int ALU_CTL_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ALU_CTL_FLUSH,
    ALU_CTL_IDLE,
    ALU_CTL_RUN,
    ALU_CTL_REL
  } alu_ctl_state_e;

endpackage

// File: rtl/mesm6_alu.sv
// rtl/mesm6_alu.sv - minimal unreset ALU: one-cycle logic/add ops, done held until op returns to NOP
module mesm6_alu
  import mesm6_alu_ctl_pkg::*;
(
  input  logic                    clk,
  input  logic [47:0]             a,
  input  logic [47:0]             b,
  input  logic [ALU_OP_WIDTH-1:0] op,
  output logic [47:0]             result,
  output logic [47:0]             y,
  output logic                    done
);

  logic [48:0] sum;
  logic [47:0] sum_eac;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign sum_eac = sum[47:0] + {47'b0, sum[48]};

  // FMUL is deliberately unimplemented here, so it never raises done.
  always_ff @(posedge clk) begin
    if (op == ALU_NOP) begin
      done <= 1'b0;
    end else if (!done) begin
      case (op)
        ALU_AND: begin
          result <= a & b;
          y      <= '0;
          done   <= 1'b1;
        end
        ALU_OR: begin
          result <= a | b;
          y      <= '0;
          done   <= 1'b1;
        end
        ALU_XOR: begin
          result <= a ^ b;
          y      <= a;
          done   <= 1'b1;
        end
        ALU_ADD_CARRY_AROUND: begin
          result <= sum_eac;
          y      <= '0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mesm6_alu_ctl.sv
// rtl/mesm6_alu_ctl.sv - ACC/Y register stage and request sequencer in front of the ALU
module mesm6_alu_ctl
  import mesm6_alu_ctl_pkg::*;
#(
  parameter int TIMEOUT = ALU_CTL_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ALU_OP_WIDTH-1:0] req_op,
  input  logic [47:0]             req_operand,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [47:0]             acc,
  output logic [47:0]             y,
  output logic [47:0]             alu_a,
  output logic [47:0]             alu_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [47:0]             alu_result,
  input  logic [47:0]             alu_y,
  input  logic                    alu_done
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  alu_ctl_state_e          state_q;
  logic [47:0]             acc_q;
  logic [47:0]             y_q;
  logic [47:0]             operand_q;
  logic [ALU_OP_WIDTH-1:0] op_q;
  logic [CW-1:0]           cnt_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;

  assign acc       = acc_q;
  assign y         = y_q;
  assign alu_a     = acc_q;
  assign alu_b     = operand_q;
  assign alu_op    = (state_q == ALU_CTL_RUN) ? op_q : ALU_NOP;
  assign req_ready = (state_q == ALU_CTL_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ALU_CTL_FLUSH;
      acc_q       <= '0;
      y_q         <= '0;
      operand_q   <= '0;
      op_q        <= ALU_NOP;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        // The ALU keeps done across our reset; one NOP cycle clears it.
        ALU_CTL_FLUSH: state_q <= ALU_CTL_IDLE;
        ALU_CTL_IDLE: begin
          if (req_valid) begin
            if (req_op != ALU_NOP) begin
              op_q      <= req_op;
              operand_q <= req_operand;
              cnt_q     <= '0;
              state_q   <= ALU_CTL_RUN;
            end else begin
              acc_q       <= req_operand;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              state_q     <= ALU_CTL_REL;
            end
          end
        end
        ALU_CTL_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (alu_done) begin
            acc_q       <= alu_result;
            y_q         <= alu_y;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            state_q     <= ALU_CTL_REL;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= ALU_CTL_REL;
          end
        end
        ALU_CTL_REL: state_q <= ALU_CTL_IDLE;
        default: state_q <= ALU_CTL_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_mesm6_alu_ctl.sv
// tb/tb_mesm6_alu_ctl.sv - directed bench for mesm6_alu_ctl driving mesm6_alu
module tb_mesm6_alu_ctl;
  import mesm6_alu_ctl_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    req_valid;
  logic                    req_ready;
  logic [ALU_OP_WIDTH-1:0] req_op;
  logic [47:0]             req_operand;
  logic                    rsp_valid;
  logic                    rsp_err;
  logic [47:0]             acc;
  logic [47:0]             y;
  logic [47:0]             alu_a;
  logic [47:0]             alu_b;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [47:0]             alu_result;
  logic [47:0]             alu_y;
  logic                    alu_done;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  mesm6_alu_ctl #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_operand (req_operand),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .acc         (acc),
    .y           (y),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_y       (alu_y),
    .alu_done    (alu_done)
  );

  mesm6_alu alu (
    .clk    (clk),
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .y      (alu_y),
    .done   (alu_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request at the first ready cycle; returns cycles from accept to rsp_valid.
  task automatic issue(input logic [ALU_OP_WIDTH-1:0] op, input logic [47:0] opnd,
                       output int latency);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    check("issue_ready", 64'(req_ready), 64'(1));
    req_valid   = 1'b1;
    req_op      = op;
    req_operand = opnd;
    tick();
    req_valid   = 1'b0;
    req_op      = ALU_NOP;
    req_operand = '0;
    latency = 1;
    while (!rsp_valid && latency < 40) begin
      tick();
      latency++;
    end
  endtask

  task automatic after_rsp(input string tag);
    tick();
    check({tag, "_no_double_rsp"}, 64'(rsp_valid), 64'(0));
    check({tag, "_ready_again"}, 64'(req_ready), 64'(1));
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b1;
    req_op      = ALU_NOP;
    req_operand = 48'hFFFF_0000_FFFF;
    tick();
    tick();
    check("rst_acc", 64'(acc), 64'(0));
    check("rst_y", 64'(y), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_alu_op", 64'(alu_op), 64'(ALU_NOP));
    check("rst_alu_b", 64'(alu_b), 64'(0));

    reset = 1'b0;
    check("flush_not_ready", 64'(req_ready), 64'(0));
    tick();
    check("idle_ready", 64'(req_ready), 64'(1));

    issue(ALU_NOP, 48'hFFFF_0000_FFFF, lat);
    check("load1_lat", 64'(lat), 64'(1));
    check("load1_acc", 64'(acc), 64'h0000_FFFF_0000_FFFF);
    check("load1_y", 64'(y), 64'(0));
    check("load1_err", 64'(rsp_err), 64'(0));
    after_rsp("load1");

    issue(ALU_AND, 48'h0F0F_0F0F_0F0F, lat);
    check("and_lat", 64'(lat), 64'(3));
    check("and_acc", 64'(acc), 64'h0000_0F0F_0000_0F0F);
    check("and_y", 64'(y), 64'(0));
    check("and_err", 64'(rsp_err), 64'(0));
    check("and_rel_op", 64'(alu_op), 64'(ALU_NOP));
    after_rsp("and");

    issue(ALU_NOP, 48'hFFFF_FFFF_FFFF, lat);
    check("load2_acc", 64'(acc), 64'h0000_FFFF_FFFF_FFFF);
    after_rsp("load2");
    issue(ALU_ADD_CARRY_AROUND, 48'h1, lat);
    check("eac_lat", 64'(lat), 64'(3));
    check("eac_acc", 64'(acc), 64'h1);
    check("eac_y", 64'(y), 64'(0));
    after_rsp("eac");

    issue(ALU_NOP, 48'h1234_5678_9ABC, lat);
    after_rsp("load3");
    issue(ALU_XOR, 48'hFFFF_FFFF_FFFF, lat);
    check("xor_acc", 64'(acc), 64'h0000_EDCB_A987_6543);
    check("xor_y", 64'(y), 64'h0000_1234_5678_9ABC);
    check("xor_err", 64'(rsp_err), 64'(0));
    after_rsp("xor");

    issue(ALU_FMUL, 48'h5, lat);
    check("fmul_lat", 64'(lat), 64'(17));
    check("fmul_err", 64'(rsp_err), 64'(1));
    check("fmul_acc", 64'(acc), 64'h0000_EDCB_A987_6543);
    check("fmul_y", 64'(y), 64'h0000_1234_5678_9ABC);
    check("fmul_op_nop", 64'(alu_op), 64'(ALU_NOP));
    after_rsp("fmul");

    req_valid   = 1'b1;
    req_op      = ALU_OR;
    req_operand = 48'h0000_0000_00FF;
    tick();
    req_valid = 1'b0;
    req_op    = ALU_NOP;
    check("or_run_op", 64'(alu_op), 64'(ALU_OR));
    check("or_run_b", 64'(alu_b), 64'h0000_0000_0000_00FF);
    check("or_run_a", 64'(alu_a), 64'h0000_EDCB_A987_6543);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_acc", 64'(acc), 64'(0));
    check("mid_rst_y", 64'(y), 64'(0));
    check("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    check("mid_rst_flush", 64'(req_ready), 64'(0));
    check("mid_rst_op", 64'(alu_op), 64'(ALU_NOP));
    tick();
    check("post_rst_rsp", 64'(rsp_valid), 64'(0));
    check("post_rst_ready", 64'(req_ready), 64'(1));

    issue(ALU_AND, 48'hFFFF_FFFF_FFFF, lat);
    check("stale_and_lat", 64'(lat), 64'(3));
    check("stale_and_acc", 64'(acc), 64'(0));
    check("stale_and_y", 64'(y), 64'(0));
    after_rsp("stale_and");

    issue(ALU_NOP, 48'hABCD_EF01_2345, lat);
    after_rsp("load4");
    issue(ALU_AND, 48'h0F0F_0F0F_0F0F, lat);
    check("and2_lat", 64'(lat), 64'(3));
    check("and2_acc", 64'(acc), 64'h0000_0B0D_0F01_0305);
    check("and2_err", 64'(rsp_err), 64'(0));
    after_rsp("and2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
